// File: rtl/load_port_arbiter.sv
// load_port_arbiter
//
// Shares one 32-bit memory read port between the IFM and Weight preload streams
// during the LOAD phase. Word reads are issued round-robin. A small in-order tag
// FIFO tracks the outstanding reads, and each returned word is routed to the IFM or
// Weight buffer write port one cycle after it arrives. done pulses once every
// requested word has been written.
//
// Build option:
//   LOAD_ARB_FIXED_PRIO_EN - IFM has fixed priority over Weight. The round-robin
//                            pointer is removed. Default (undefined): round robin.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start_i             one-cycle pulse; latches sizes and bases; honoured only in idle
//   ifm_bytes_i         IFM byte count
//   wgt_bytes_i         Weight byte count
//   ifm_base_i          IFM byte base address
//   wgt_base_i          Weight byte base address
//   mem_req_o           read request valid
//   mem_addr_o          read byte address
//   mem_gnt_i           request accepted when mem_req_o && mem_gnt_i
//   mem_rvalid_i        read data valid; responses return in request order
//   mem_rdata_i         read data
//   ifm_wr_en_o         IFM buffer write strobe
//   ifm_wr_addr_o       IFM buffer word address
//   wgt_wr_en_o         Weight buffer write strobe
//   wgt_wr_addr_o       Weight buffer word address
//   wr_data_o           write data shared by both buffers
//   busy_o              high while the load is issuing or draining
//   done_o              one-cycle completion pulse
//   err_o               sticky: a response arrived with no read outstanding
module load_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned LADDR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [31:0]        ifm_bytes_i,
    input  logic [31:0]        wgt_bytes_i,
    input  logic [ADDR_W-1:0]  ifm_base_i,
    input  logic [ADDR_W-1:0]  wgt_base_i,
    output logic               mem_req_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    input  logic               mem_gnt_i,
    input  logic               mem_rvalid_i,
    input  logic [DATA_W-1:0]  mem_rdata_i,
    output logic               ifm_wr_en_o,
    output logic [LADDR_W-1:0] ifm_wr_addr_o,
    output logic               wgt_wr_en_o,
    output logic [LADDR_W-1:0] wgt_wr_addr_o,
    output logic [DATA_W-1:0]  wr_data_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e state_q;
    logic   busy_q;
    logic   done_q;

    // Issue side: words left to request and next byte address, per stream.
    logic [31:0]       ifm_left_q, wgt_left_q;
    logic [ADDR_W-1:0] ifm_addr_q, wgt_addr_q;
    logic [31:0]       ifm_words, wgt_words;

    // Tag FIFO: one bit per outstanding read, 0 = IFM, 1 = Weight.
    logic [MAX_OUT-1:0] tag_fifo_q;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   out_cnt_q;

    // Return side: per-stream arrival counters and the registered write port.
    logic [LADDR_W-1:0] ifm_ret_q, wgt_ret_q;
    logic               ifm_wr_en_q, wgt_wr_en_q;
    logic [LADDR_W-1:0] ifm_wr_addr_q, wgt_wr_addr_q;
    logic [DATA_W-1:0]  wr_data_q;
    logic               err_q;

    logic start_acc;
    logic ifm_has, wgt_has;
    logic not_full;
    logic sel_wgt;
    logic accept;
    logic pop;
    logic pop_tag;
    logic wr_pend;

    // Word count rounds partial words up; the 34-bit sum cannot overflow.
    assign ifm_words = 32'(({2'b00, ifm_bytes_i} + 34'd3) >> 2);
    assign wgt_words = 32'(({2'b00, wgt_bytes_i} + 34'd3) >> 2);

    assign start_acc = start_i && (state_q == StIdle);
    assign ifm_has   = (ifm_left_q != '0);
    assign wgt_has   = (wgt_left_q != '0);
    assign not_full  = (out_cnt_q < CNT_W'(MAX_OUT));

`ifdef LOAD_ARB_FIXED_PRIO_EN
    // The only stall is the shared outstanding limit, so IFM is never blocked
    // on its own; Weight goes only once IFM has nothing left to issue.
    assign sel_wgt = !ifm_has;
`else
    logic rr_ptr_q;  // 1: Weight is favoured for the next accept

    assign sel_wgt = wgt_has && (!ifm_has || rr_ptr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 1'b0;
        end else if (start_acc) begin
            rr_ptr_q <= 1'b0;
        end else if (accept) begin
            rr_ptr_q <= !sel_wgt;
        end
    end
`endif

    // Selection depends only on registered state that changes on accept, so the
    // presented address holds steady while the port stalls.
    assign mem_req_o  = (state_q == StIssue) && (ifm_has || wgt_has) && not_full;
    assign mem_addr_o = sel_wgt ? wgt_addr_q : ifm_addr_q;
    assign accept     = mem_req_o && mem_gnt_i;

    // A response with nothing outstanding is dropped, even if a push lands the
    // same cycle.
    assign pop     = mem_rvalid_i && (out_cnt_q != '0);
    assign pop_tag = tag_fifo_q[rd_ptr_q];
    assign wr_pend = ifm_wr_en_q || wgt_wr_en_q;

    // Issue counters and addresses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifm_left_q <= '0;
            wgt_left_q <= '0;
            ifm_addr_q <= '0;
            wgt_addr_q <= '0;
        end else if (start_acc) begin
            ifm_left_q <= ifm_words;
            wgt_left_q <= wgt_words;
            ifm_addr_q <= ifm_base_i;
            wgt_addr_q <= wgt_base_i;
        end else if (accept) begin
            if (sel_wgt) begin
                wgt_left_q <= wgt_left_q - 32'd1;
                wgt_addr_q <= wgt_addr_q + ADDR_W'(4);
            end else begin
                ifm_left_q <= ifm_left_q - 32'd1;
                ifm_addr_q <= ifm_addr_q + ADDR_W'(4);
            end
        end
    end

    // Tag FIFO and outstanding count. MAX_OUT is a power of two, so the
    // pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_fifo_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            out_cnt_q  <= '0;
        end else begin
            if (accept) begin
                tag_fifo_q[wr_ptr_q] <= sel_wgt;
                wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({accept, pop})
                2'b10:   out_cnt_q <= out_cnt_q + CNT_W'(1);
                2'b01:   out_cnt_q <= out_cnt_q - CNT_W'(1);
                default: out_cnt_q <= out_cnt_q;
            endcase
        end
    end

    // Write stage: one cycle after the response, addressed by arrival order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifm_ret_q     <= '0;
            wgt_ret_q     <= '0;
            ifm_wr_en_q   <= 1'b0;
            wgt_wr_en_q   <= 1'b0;
            ifm_wr_addr_q <= '0;
            wgt_wr_addr_q <= '0;
            wr_data_q     <= '0;
        end else begin
            ifm_wr_en_q <= pop && !pop_tag;
            wgt_wr_en_q <= pop && pop_tag;
            if (pop) begin
                wr_data_q <= mem_rdata_i;
            end
            if (start_acc) begin
                ifm_ret_q <= '0;
                wgt_ret_q <= '0;
            end else if (pop) begin
                if (pop_tag) begin
                    wgt_wr_addr_q <= wgt_ret_q;
                    wgt_ret_q     <= wgt_ret_q + LADDR_W'(1);
                end else begin
                    ifm_wr_addr_q <= ifm_ret_q;
                    ifm_ret_q     <= ifm_ret_q + LADDR_W'(1);
                end
            end
        end
    end

    // A stray response wins over a start that lands in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (mem_rvalid_i && (out_cnt_q == '0)) begin
            err_q <= 1'b1;
        end else if (start_acc) begin
            err_q <= 1'b0;
        end
    end

    // Control FSM with registered busy/done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StIssue;
                        busy_q  <= 1'b1;
                    end
                end
                StIssue: begin
                    if (!ifm_has && !wgt_has) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    // Wait for the last response and for its write to retire.
                    if ((out_cnt_q == '0) && !wr_pend) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ifm_wr_en_o   = ifm_wr_en_q;
    assign wgt_wr_en_o   = wgt_wr_en_q;
    assign ifm_wr_addr_o = ifm_wr_addr_q;
    assign wgt_wr_addr_o = wgt_wr_addr_q;
    assign wr_data_o     = wr_data_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_load_port_arbiter.sv
// Bench for load_port_arbiter: a memory model with configurable read latency and
// grant pattern, a write scoreboard fed as responses are driven, a table of load
// sizes, and hand-written sequences for address order, stray responses and reset.
module tb_load_port_arbiter;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned MAX_OUT = 4;
    localparam int unsigned LADDR_W = 16;
    localparam logic [31:0] IFM_BASE = 32'h1000_0000;
    localparam logic [31:0] WGT_BASE = 32'h2000_0000;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [31:0]        ifm_bytes, wgt_bytes;
    logic [ADDR_W-1:0]  ifm_base, wgt_base;
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_gnt;
    logic               mem_rvalid;
    logic [DATA_W-1:0]  mem_rdata;
    logic               ifm_wr_en, wgt_wr_en;
    logic [LADDR_W-1:0] ifm_wr_addr, wgt_wr_addr;
    logic [DATA_W-1:0]  wr_data;
    logic               busy, done, err;

    load_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .MAX_OUT(MAX_OUT),
        .LADDR_W(LADDR_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .ifm_bytes_i  (ifm_bytes),
        .wgt_bytes_i  (wgt_bytes),
        .ifm_base_i   (ifm_base),
        .wgt_base_i   (wgt_base),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_gnt_i    (mem_gnt),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .ifm_wr_en_o  (ifm_wr_en),
        .ifm_wr_addr_o(ifm_wr_addr),
        .wgt_wr_en_o  (wgt_wr_en),
        .wgt_wr_addr_o(wgt_wr_addr),
        .wr_data_o    (wr_data),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic        wgt;
        logic [15:0] idx;
        logic [31:0] data;
    } exp_wr_t;

    pend_t       pend_q[$];
    exp_wr_t     sb_q[$];
    logic [31:0] acc_q[$];

    int   cyc = 0;
    int   lat_cfg = 1;
    int   gnt_mode = 0;
    int   peak = 0;
    int   n_ifm_wr = 0;
    int   n_wgt_wr = 0;
    int   n_done = 0;
    logic inject_stray = 1'b0;
    logic req_wait = 1'b0;
    logic [31:0] wait_addr = '0;

    pend_t       p;
    exp_wr_t     e;
    exp_wr_t     m;
    logic [31:0] off;

    // Memory model, scoreboard push and write monitor, all away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend_q.delete();
            sb_q.delete();
            mem_rvalid = 1'b0;
            req_wait   = 1'b0;
        end else begin
            if (ifm_wr_en || wgt_wr_en) begin
                if (ifm_wr_en) n_ifm_wr++;
                if (wgt_wr_en) n_wgt_wr++;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected write: ifm_en=%0b wgt_en=%0b data=%0h, expected no write",
                             ifm_wr_en, wgt_wr_en, wr_data);
                end else begin
                    m = sb_q.pop_front();
                    check("write", 128'({wgt_wr_en, ifm_wr_en,
                                         (wgt_wr_en ? wgt_wr_addr : ifm_wr_addr), wr_data}),
                          128'({m.wgt, ~m.wgt, m.idx, m.data}));
                end
            end
            if (done) n_done++;

            mem_rvalid = 1'b0;
            if (inject_stray) begin
                mem_rvalid   = 1'b1;
                mem_rdata    = 32'hDEAD_BEEF;
                inject_stray = 1'b0;
            end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                p          = pend_q.pop_front();
                mem_rvalid = 1'b1;
                mem_rdata  = p.addr ^ 32'h5A5A_C3C3;
                e.wgt      = (p.addr >= WGT_BASE);
                off        = p.addr - (e.wgt ? WGT_BASE : IFM_BASE);
                e.idx      = off[17:2];
                e.data     = mem_rdata;
                sb_q.push_back(e);
            end

            mem_gnt = (gnt_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            if (mem_req) begin
                if (req_wait) check("addr stable while stalled", 128'(mem_addr), 128'(wait_addr));
                if (mem_gnt) begin
                    p.addr = mem_addr;
                    p.due  = cyc + lat_cfg;
                    pend_q.push_back(p);
                    acc_q.push_back(mem_addr);
                    if (pend_q.size() > peak) peak = pend_q.size();
                    req_wait = 1'b0;
                end else begin
                    req_wait  = 1'b1;
                    wait_addr = mem_addr;
                end
            end else begin
                req_wait = 1'b0;
            end
            cyc++;
        end
    end

    task automatic clear_stats();
        peak     = 0;
        n_ifm_wr = 0;
        n_wgt_wr = 0;
        n_done   = 0;
        acc_q.delete();
    endtask

    // Runs one load; dlat is the number of cycles from the start cycle to done.
    task automatic run_load(input logic [31:0] ib, input logic [31:0] wb, input int lat,
                            input int gm, output int dlat);
        lat_cfg  = lat;
        gnt_mode = gm;
        clear_stats();
        @(negedge clk);
        ifm_bytes = ib;
        wgt_bytes = wb;
        start     = 1'b1;
        dlat      = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            start = 1'b0;
            dlat++;
            if (dlat == 1) begin
                check("busy after start", 128'(busy), 128'(1));
                check("err cleared by start", 128'(err), 128'(0));
            end
            if (done) break;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL load timeout: done=%0b after %0d cycles, expected done=1", done, dlat);
        end
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] ib;
        logic [31:0] wb;
        int          lat;
        int          gm;
        int          exp_ifm;
        int          exp_wgt;
        int          exp_peak;
        int          exp_dlat;
    } vec_t;

    vec_t        vecs[6];
    int          dl;
    logic [31:0] seq6[6];
    logic [31:0] seq4[4];

    task automatic check_seq6(input string name);
        check({name, " count"}, 128'(acc_q.size()), 128'(6));
        for (int i = 0; i < 6 && i < acc_q.size(); i++)
            check(name, 128'(acc_q[i]), 128'(seq6[i]));
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        ifm_bytes  = '0;
        wgt_bytes  = '0;
        ifm_base   = IFM_BASE;
        wgt_base   = WGT_BASE;
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;

        //           ib  wb  lat gm ifm wgt peak dlat
        vecs[0] = '{32'd16, 32'd8,  1, 0, 4,  2, 1, 0};
        vecs[1] = '{32'd6,  32'd0,  1, 0, 2,  0, 1, 0};
        vecs[2] = '{32'd0,  32'd0,  1, 0, 0,  0, 0, 3};
        vecs[3] = '{32'd40, 32'd20, 8, 0, 10, 5, 4, 0};
        vecs[4] = '{32'd13, 32'd27, 3, 1, 4,  7, -1, 0};
        vecs[5] = '{32'd1,  32'd5,  4, 0, 1,  2, 3, 0};

        repeat (2) @(negedge clk);
        #1;
        check("reset outputs", 128'({mem_req, mem_addr, ifm_wr_en, ifm_wr_addr, wgt_wr_en,
                                     wgt_wr_addr, wr_data, busy, done, err}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            run_load(vecs[v].ib, vecs[v].wb, vecs[v].lat, vecs[v].gm, dl);
            check($sformatf("v%0d ifm writes", v), 128'(n_ifm_wr), 128'(vecs[v].exp_ifm));
            check($sformatf("v%0d wgt writes", v), 128'(n_wgt_wr), 128'(vecs[v].exp_wgt));
            check($sformatf("v%0d accepts", v), 128'(acc_q.size()),
                  128'(vecs[v].exp_ifm + vecs[v].exp_wgt));
            check($sformatf("v%0d done pulses", v), 128'(n_done), 128'(1));
            check($sformatf("v%0d err", v), 128'(err), 128'(0));
            check($sformatf("v%0d busy after done", v), 128'(busy), 128'(0));
            check($sformatf("v%0d scoreboard drained", v), 128'(sb_q.size()), 128'(0));
            if (vecs[v].exp_peak >= 0)
                check($sformatf("v%0d peak outstanding", v), 128'(peak), 128'(vecs[v].exp_peak));
            if (vecs[v].exp_dlat > 0)
                check($sformatf("v%0d done latency", v), 128'(dl), 128'(vecs[v].exp_dlat));
        end

        // Address order, 16/8 bytes.
`ifdef LOAD_ARB_FIXED_PRIO_EN
        seq6 = '{IFM_BASE, IFM_BASE + 4, IFM_BASE + 8, IFM_BASE + 12, WGT_BASE, WGT_BASE + 4};
        seq4 = '{IFM_BASE, IFM_BASE + 4, WGT_BASE, WGT_BASE + 4};
`else
        seq6 = '{IFM_BASE, WGT_BASE, IFM_BASE + 4, WGT_BASE + 4, IFM_BASE + 8, IFM_BASE + 12};
        seq4 = '{IFM_BASE, WGT_BASE, IFM_BASE + 4, WGT_BASE + 4};
`endif
        run_load(32'd16, 32'd8, 1, 0, dl);
        check_seq6("order 16/8");

        // Address order, 8/8 bytes.
        run_load(32'd8, 32'd8, 1, 0, dl);
        check("order 8/8 count", 128'(acc_q.size()), 128'(4));
        for (int i = 0; i < 4 && i < acc_q.size(); i++)
            check("order 8/8", 128'(acc_q[i]), 128'(seq4[i]));

        // Stray response while idle: sticky err, no write; next start clears it.
        clear_stats();
        @(negedge clk);
        inject_stray = 1'b1;
        repeat (3) @(negedge clk);
        check("stray err set", 128'(err), 128'(1));
        check("stray no write", 128'(n_ifm_wr + n_wgt_wr), 128'(0));
        run_load(32'd8, 32'd0, 1, 0, dl);
        check("after stray ifm writes", 128'(n_ifm_wr), 128'(2));

        // Reset in mid-load, then a clean load from word 0.
        clear_stats();
        lat_cfg  = 4;
        gnt_mode = 0;
        @(negedge clk);
        ifm_bytes = 32'd64;
        wgt_bytes = 32'd64;
        start     = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (acc_q.size() >= 3) break;
        end
        check("accepts before reset", 128'(acc_q.size() >= 3), 128'(1));
        rst_n = 1'b0;
        #1;
        check("mid-load reset outputs", 128'({mem_req, mem_addr, ifm_wr_en, ifm_wr_addr,
                                              wgt_wr_en, wgt_wr_addr, wr_data, busy, done,
                                              err}), 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_load(32'd16, 32'd8, 1, 0, dl);
        check_seq6("order after reset");
        check("after reset ifm writes", 128'(n_ifm_wr), 128'(4));
        check("after reset wgt writes", 128'(n_wgt_wr), 128'(2));
        check("after reset done pulses", 128'(n_done), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
